// File: rtl/dmem_stall_pkg.sv
// Shared state encodings and access-latency selection for the MEM-stage stall controller.
package dmem_stall_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } stallState_t;

  // A simultaneous load and store is treated as a store.
  function automatic int selLatency(input logic isRead, input logic isWrite,
                                    input int readLat, input int writeLat);
    if (isWrite) return writeLat;
    else if (isRead) return readLat;
    else return 0;
  endfunction

endpackage

// File: rtl/perf_sat_counter.sv
// Enable-driven incrementing counter that sticks at all-ones.
module perf_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (en && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory stall generator: fixed-latency or ack handshake with timeout.
//
// state | meaning
// IDLE  | no access in flight; accepts a new load/store
// WAIT  | pipeline frozen; counting latency down (fixed) or waiting for ack (handshake)
// DONE  | access complete; instruction leaves MEM at this edge
module dmem_stall_ctrl
  import dmem_stall_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int USE_ACK   = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              kill,
  input  logic              mem_ack,
  input  logic              err_clr,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_done,
  output logic              timeout_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  stallState_t      state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, accLat;
  logic             req, errSet;

  assign req    = mem_read | mem_write;
  assign accLat = CNT_W'(selLatency(mem_read, mem_write, READ_LAT, WRITE_LAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    mem_stall = 1'b0;
    mem_req   = 1'b0;
    mem_done  = 1'b0;
    errSet    = 1'b0;
    if (kill) begin
      stateNext = IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (USE_ACK != 0) begin
              mem_stall = 1'b1;
              mem_req   = 1'b1;
              cntNext   = '0;
              stateNext = mem_ack ? DONE : WAIT;
            end else if (accLat == '0) begin
              mem_done = 1'b1;
            end else begin
              mem_stall = 1'b1;
              mem_req   = 1'b1;
              cntNext   = accLat - CNT_W'(1);
              stateNext = (accLat == CNT_W'(1)) ? DONE : WAIT;
            end
          end
        end
        WAIT: begin
          mem_stall = 1'b1;
          if (USE_ACK != 0) begin
            cntNext = cnt + CNT_W'(1);
            // An ack arriving on the timeout cycle still counts as a clean completion.
            if (mem_ack) begin
              stateNext = DONE;
            end else if (cnt == TIMEOUT_LAST) begin
              stateNext = DONE;
              errSet    = 1'b1;
            end
          end else begin
            cntNext = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) stateNext = DONE;
          end
        end
        DONE: begin
          mem_done  = 1'b1;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timeout_err <= 1'b0;
    else if (errSet) timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

  perf_sat_counter #(.W(PERF_W)) uPerf (
    .clk   (clk),
    .reset (reset),
    .en    (mem_stall),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Drives three differently configured controllers with shared stimulus against a per-instance reference model.
module tb_dmem_stall_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_read = 1'b0, mem_write = 1'b0, kill = 1'b0, mem_ack = 1'b0, err_clr = 1'b0;

  logic [2:0]  stallO, reqO, doneO, errO;
  logic [3:0]  perfA;
  logic [31:0] perfB;
  logic [7:0]  perfC;
  logic [63:0] perfO [3];

  always #5 clk = ~clk;

  always_comb begin
    perfO[0] = 64'(perfA);
    perfO[1] = 64'(perfB);
    perfO[2] = 64'(perfC);
  end

  dmem_stall_ctrl #(.READ_LAT(2), .WRITE_LAT(0), .USE_ACK(0), .TIMEOUT(64), .CNT_W(8), .PERF_W(4)) dutA (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .kill(kill),
    .mem_ack(mem_ack), .err_clr(err_clr), .mem_stall(stallO[0]), .mem_req(reqO[0]),
    .mem_done(doneO[0]), .timeout_err(errO[0]), .stall_cycles(perfA));

  dmem_stall_ctrl #(.READ_LAT(4), .WRITE_LAT(1), .USE_ACK(0), .TIMEOUT(64), .CNT_W(8), .PERF_W(32)) dutB (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .kill(kill),
    .mem_ack(mem_ack), .err_clr(err_clr), .mem_stall(stallO[1]), .mem_req(reqO[1]),
    .mem_done(doneO[1]), .timeout_err(errO[1]), .stall_cycles(perfB));

  dmem_stall_ctrl #(.READ_LAT(2), .WRITE_LAT(1), .USE_ACK(1), .TIMEOUT(8), .CNT_W(4), .PERF_W(8)) dutC (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .kill(kill),
    .mem_ack(mem_ack), .err_clr(err_clr), .mem_stall(stallO[2]), .mem_req(reqO[2]),
    .mem_done(doneO[2]), .timeout_err(errO[2]), .stall_cycles(perfC));

  // Reference configuration, indexed by instance.
  int     rl     [3] = '{2, 4, 2};
  int     wl     [3] = '{0, 1, 1};
  bit     useAck [3] = '{0, 0, 1};
  int     tmo    [3] = '{64, 64, 8};
  longint perfMax[3] = '{15, 64'hFFFF_FFFF, 255};

  // Model: stall cycles still owed, pending completion, and handshake wait progress.
  int     remain  [3];
  bit     donePend[3];
  bit     inWait  [3];
  int     waited  [3];
  bit     errM    [3];
  longint perfM   [3];

  int nCompared = 0;
  int nMismatch = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      remain[d] = 0; donePend[d] = 0; inWait[d] = 0; waited[d] = 0; errM[d] = 0; perfM[d] = 0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkVal($sformatf("%s_stall%0d", tag, d), 64'(stallO[d]), 64'd0);
      checkVal($sformatf("%s_req%0d", tag, d), 64'(reqO[d]), 64'd0);
      checkVal($sformatf("%s_done%0d", tag, d), 64'(doneO[d]), 64'd0);
      checkVal($sformatf("%s_err%0d", tag, d), 64'(errO[d]), 64'd0);
      checkVal($sformatf("%s_perf%0d", tag, d), perfO[d], 64'd0);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic runCycle(input logic rd, input logic wr, input logic kl, input logic ack, input logic clr);
    bit expStall, expReq, expDone, errSet;
    int lat;
    mem_read = rd; mem_write = wr; kill = kl; mem_ack = ack; err_clr = clr;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      expStall = 0; expReq = 0; expDone = 0; errSet = 0;
      checkVal($sformatf("err%0d", d), 64'(errO[d]), 64'(errM[d]));
      checkVal($sformatf("perf%0d", d), perfO[d], 64'(perfM[d]));
      if (kl) begin
        remain[d] = 0; donePend[d] = 0; inWait[d] = 0;
      end else if (donePend[d]) begin
        expDone = 1; donePend[d] = 0;
      end else if (useAck[d]) begin
        if (inWait[d]) begin
          expStall = 1;
          if (ack) begin
            inWait[d] = 0; donePend[d] = 1;
          end else if (waited[d] == tmo[d] - 1) begin
            inWait[d] = 0; donePend[d] = 1; errSet = 1;
          end else begin
            waited[d]++;
          end
        end else if (rd | wr) begin
          expStall = 1; expReq = 1;
          if (ack) donePend[d] = 1;
          else begin inWait[d] = 1; waited[d] = 0; end
        end
      end else begin
        if (remain[d] > 0) begin
          expStall = 1;
          remain[d]--;
          if (remain[d] == 0) donePend[d] = 1;
        end else if (rd | wr) begin
          lat = wr ? wl[d] : rl[d];
          if (lat == 0) expDone = 1;
          else begin
            expStall = 1; expReq = 1;
            remain[d] = lat - 1;
            if (remain[d] == 0) donePend[d] = 1;
          end
        end
      end
      checkVal($sformatf("stall%0d", d), 64'(stallO[d]), 64'(expStall));
      checkVal($sformatf("req%0d", d), 64'(reqO[d]), 64'(expReq));
      checkVal($sformatf("done%0d", d), 64'(doneO[d]), 64'(expDone));
      if (errSet) errM[d] = 1;
      else if (clr) errM[d] = 0;
      if (expStall && perfM[d] < perfMax[d]) perfM[d]++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("rst");
    reset = 1'b0;

    // Load held four cycles, then a store streamed five cycles.
    repeat (4) runCycle(1, 0, 0, 0, 0);
    repeat (5) runCycle(0, 1, 0, 0, 0);
    repeat (8) runCycle(0, 0, 0, 0, 0);

    // Handshake ack three cycles after the request.
    runCycle(1, 0, 0, 0, 0);
    repeat (2) runCycle(1, 0, 0, 0, 0);
    runCycle(1, 0, 0, 1, 0);
    repeat (4) runCycle(0, 0, 0, 0, 0);

    // Two timeouts; the second coincides with err_clr.
    repeat (10) runCycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) runCycle(1, 0, 0, 0, (i == 8));
    repeat (4) runCycle(0, 0, 0, 0, 1);

    // Kill during the second WAIT cycle, then a fresh load.
    runCycle(1, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0);
    runCycle(1, 0, 1, 0, 0);
    repeat (6) runCycle(1, 0, 0, 0, 0);
    repeat (4) runCycle(0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an access.
    runCycle(1, 0, 0, 0, 0);
    runCycle(1, 0, 0, 0, 0);
    #2;
    mem_read = 0; mem_write = 0; kill = 0; mem_ack = 0; err_clr = 0;
    reset = 1'b1;
    #1;
    checkAllZero("arst");
    #2;
    reset = 1'b0;
    modelReset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      runCycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
